// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its environment: timing generator,
// host write port, VRAM port and display line-buffer write port.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12,
    parameter int IDX_W  = 7
);
    logic              line_start;
    logic [ADDR_W-1:0] line_base;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lb_we;
    logic [IDX_W-1:0]  lb_idx;
    logic [DATA_W-1:0] lb_data;
    logic              fetch_busy;
    logic              overrun;

    modport slave (
        input  line_start, line_base, host_req, host_addr, host_wdata, mem_rdata,
        output host_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_idx, lb_data,
               fetch_busy, overrun
    );

    modport master (
        output line_start, line_base, host_req, host_addr, host_wdata, mem_rdata,
        input  host_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_idx, lb_data,
               fetch_busy, overrun
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanline burst fetch with absolute priority
// over single-word host writes. Define VRAM_ARB_OVERRUN_EN for the sticky overrun flag.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int LINE_WORDS = 100,
    parameter int IDX_W      = 7
) (
    input  logic           clk40,
    input  logic           areset,
    vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_host_ack;
    logic              r_lb_we;
    logic [IDX_W-1:0]  r_lb_idx;
    logic              r_busy;
    logic              w_accept_host;

    // host_ack blocks the next edge so a held request is never written twice
    assign w_accept_host = bus.host_req && !bus.line_start && !r_host_ack;

    always_ff @(posedge clk40 or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_host_ack  <= 1'b0;
            r_lb_we     <= 1'b0;
            r_lb_idx    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_host_ack <= 1'b0;
            r_lb_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.line_start) begin
                        r_state    <= FETCH;
                        r_mem_addr <= bus.line_base;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                    end else if (w_accept_host) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= bus.host_addr;
                        r_mem_wdata <= bus.host_wdata;
                        r_host_ack  <= 1'b1;
                    end
                end
                FETCH: begin
                    // read data for index r_cnt returns next cycle
                    r_lb_we  <= 1'b1;
                    r_lb_idx <= r_cnt;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.lb_we      = r_lb_we;
    assign bus.lb_idx     = r_lb_idx;
    assign bus.lb_data    = r_lb_we ? bus.mem_rdata : '0;
    assign bus.fetch_busy = r_busy;

`ifdef VRAM_ARB_OVERRUN_EN
    logic       r_overrun;
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk40 or posedge areset) begin
        if (areset) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (bus.line_start && r_state != IDLE) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != '1) r_ovr_cnt <= r_ovr_cnt + 1'b1;
        end
    end

    assign bus.overrun = r_overrun;
`else
    assign bus.overrun = 1'b0;
`endif
endmodule
